// File: rtl/seq_gen_1011.sv
// rtl/seq_gen_1011.sv - serial pattern transmitter, MSB-first, with repeat count and idle gaps
module seq_gen_1011 #(
  parameter int                 PAT_LEN    = 4,
  parameter logic [PAT_LEN-1:0] PATTERN    = 4'b1011,
  parameter int                 CNT_W      = 8,
  parameter int                 GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             dout,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_MSB  = IW'(PAT_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [CNT_W-1:0] reps, reps_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             dout_n, bv_n, busy_n, done_n;

  // idx names the bit currently on dout; reps counts repetitions still owed, including the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      reps      <= '0;
      gap_cnt   <= '0;
      dout      <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      reps      <= reps_n;
      gap_cnt   <= gap_n;
      dout      <= dout_n;
      bit_valid <= bv_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    reps_n  = reps;
    gap_n   = gap_cnt;
    dout_n  = 1'b0;
    bv_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          reps_n = rep_cnt;
          if (rep_cnt != '0) begin
            state_n = SEND;
            idx_n   = IDX_MSB;
            dout_n  = PATTERN[IDX_MSB];
            bv_n    = 1'b1;
            busy_n  = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_n = IDLE;
          reps_n  = '0;
          idx_n   = '0;
        end else if (idx != '0) begin
          idx_n  = idx - 1'b1;
          dout_n = PATTERN[idx_n];
          bv_n   = 1'b1;
          busy_n = 1'b1;
        end else if (reps > CNT_W'(1)) begin
          reps_n = reps - 1'b1;
          busy_n = 1'b1;
          if (GAP_CYCLES == 0) begin
            idx_n  = IDX_MSB;
            dout_n = PATTERN[IDX_MSB];
            bv_n   = 1'b1;
          end else begin
            state_n = GAP;
            gap_n   = GAP_LAST;
          end
        end else begin
          state_n = IDLE;
          reps_n  = '0;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_n = IDLE;
          reps_n  = '0;
          gap_n   = '0;
        end else begin
          busy_n = 1'b1;
          if (gap_cnt == '0) begin
            state_n = SEND;
            idx_n   = IDX_MSB;
            dout_n  = PATTERN[IDX_MSB];
            bv_n    = 1'b1;
          end else begin
            gap_n = gap_cnt - 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_gen_1011.sv
// tb/tb_seq_gen_1011.sv - directed self-checking bench for seq_gen_1011
module tb_seq_gen_1011;

  logic       clk = 1'b0;
  logic       reset, start, abort, start_g, abort_g;
  logic [7:0] rep_cnt, rep_g;
  logic       dout, bit_valid, busy, done;
  logic       dout_g, bv_g, busy_g, done_g;
  int         n_checks = 0;
  int         n_fail = 0;
  int         hits;
  logic [3:0] sr;
  logic [3:0]  pat   = 4'b1011;
  logic [11:0] seq12 = 12'b101110111011;
  logic [9:0]  gap_d = 10'b1011001011;
  logic [9:0]  gap_v = 10'b1111001111;

  always #5 clk = ~clk;

  seq_gen_1011 dut (
    .clk(clk), .reset(reset), .start(start), .rep_cnt(rep_cnt), .abort(abort),
    .dout(dout), .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  seq_gen_1011 #(.GAP_CYCLES(2)) dut_g (
    .clk(clk), .reset(reset), .start(start_g), .rep_cnt(rep_g), .abort(abort_g),
    .dout(dout_g), .bit_valid(bv_g), .busy(busy_g), .done(done_g)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed={dout,valid,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rep_cnt = '0;
    start_g = 1'b0; abort_g = 1'b0; rep_g = '0;
    tick; tick;
    chk("reset_main", {dout, bit_valid, busy, done}, 4'b0000);
    chk("reset_gap", {dout_g, bv_g, busy_g, done_g}, 4'b0000);
    reset = 1'b0;
    tick;

    // single repetition
    rep_cnt = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_bit", {dout, bit_valid, busy, done}, {pat[3-i], 3'b110});
      tick;
    end
    chk("t1_done", {dout, bit_valid, busy, done}, 4'b0001);
    tick;
    chk("t1_idle", {dout, bit_valid, busy, done}, 4'b0000);

    // three back-to-back repetitions, counted by a bench-side 1011 detector
    hits = 0; sr = '0;
    rep_cnt = 8'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("t2_bit", {dout, bit_valid, busy, done}, {seq12[11-i], 3'b110});
      if (bit_valid) begin
        sr = {sr[2:0], dout};
        if (sr == 4'b1011) hits++;
      end
      tick;
    end
    chk("t2_done", {dout, bit_valid, busy, done}, 4'b0001);
    chk("t2_hits", hits[3:0], 4'd3);
    tick;

    // gap of two cycles between repetitions
    rep_g = 8'd2; start_g = 1'b1;
    tick;
    start_g = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_bit", {dout_g, bv_g, busy_g, done_g}, {gap_d[9-i], gap_v[9-i], 2'b10});
      tick;
    end
    chk("t3_done", {dout_g, bv_g, busy_g, done_g}, 4'b0001);
    tick;
    chk("t3_idle", {dout_g, bv_g, busy_g, done_g}, 4'b0000);

    // zero repetitions, then a start coinciding with done
    rep_cnt = 8'd0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("t4_done", {dout, bit_valid, busy, done}, 4'b0001);
    rep_cnt = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    chk("t4_restart", {dout, bit_valid, busy, done}, 4'b1110);
    for (int i = 1; i < 4; i++) begin
      tick;
      chk("t4_bit", {dout, bit_valid, busy, done}, {pat[3-i], 3'b110});
    end
    tick;
    chk("t4_done2", {dout, bit_valid, busy, done}, 4'b0001);
    tick;

    // start re-pulsed while busy is ignored
    rep_cnt = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_bit", {dout, bit_valid, busy, done}, {pat[3-i], 3'b110});
      if (i == 0) begin rep_cnt = 8'd5; start = 1'b1; end
      else start = 1'b0;
      tick;
    end
    chk("t5_done", {dout, bit_valid, busy, done}, 4'b0001);
    tick;
    chk("t5_noqueue", {dout, bit_valid, busy, done}, 4'b0000);

    // abort mid-transmission (pass 0) and reset mid-transmission (pass 1)
    for (int pass = 0; pass < 2; pass++) begin
      rep_cnt = 8'd2; start = 1'b1;
      tick;
      start = 1'b0;
      chk("t6_first", {dout, bit_valid, busy, done}, 4'b1110);
      tick;
      if (pass == 0) abort = 1'b1; else reset = 1'b1;
      tick;
      abort = 1'b0; reset = 1'b0;
      chk("t6_stopped", {dout, bit_valid, busy, done}, 4'b0000);
      tick;
      chk("t6_nodone", {dout, bit_valid, busy, done}, 4'b0000);
      rep_cnt = 8'd1; start = 1'b1; abort = 1'b1;
      tick;
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
        chk("t6_resend", {dout, bit_valid, busy, done}, {pat[3-i], 3'b110});
        tick;
      end
      chk("t6_done", {dout, bit_valid, busy, done}, 4'b0001);
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
